// File: rtl/regs_arbiter_pkg.sv
// Client indices, FSM encoding and the round-robin ring helper shared by the
// register-port arbiter and its picker.
package regs_arbiter_pkg;

  localparam int NUM_CLI = 4;

  localparam logic [1:0] CLI_TX     = 2'd0;
  localparam logic [1:0] CLI_RX     = 2'd1;
  localparam logic [1:0] CLI_HRESET = 2'd2;
  localparam logic [1:0] CLI_TCPM   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_RESP     = 2'd2
  } state_e;

  // Ring order Tx -> Rx -> tcpm -> Tx; HReset is never part of the ring.
  function automatic logic [1:0] rr_next(input logic [1:0] cli);
    logic [1:0] nxt;
    case (cli)
      CLI_TX:  nxt = CLI_RX;
      CLI_RX:  nxt = CLI_TCPM;
      default: nxt = CLI_TX;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/regs_arbiter_rr_picker.sv
// Combinational winner selection: HReset has absolute priority, the other
// three clients are scanned round-robin starting at the rr pointer.
module regs_arbiter_rr_picker
  import regs_arbiter_pkg::*;
(
  input  logic [NUM_CLI-1:0] i_req_vec,
  input  logic [1:0]         i_rr_ptr,
  output logic [1:0]         o_winner,
  output logic               o_valid
);

  logic [1:0] w_cand0;
  logic [1:0] w_cand1;
  logic [1:0] w_cand2;

  always_comb begin
    w_cand0  = i_rr_ptr;
    w_cand1  = rr_next(w_cand0);
    w_cand2  = rr_next(w_cand1);
    o_valid  = |i_req_vec;
    o_winner = CLI_TX;
    if (i_req_vec[CLI_HRESET]) begin
      o_winner = CLI_HRESET;
    end else if (i_req_vec[w_cand0]) begin
      o_winner = w_cand0;
    end else if (i_req_vec[w_cand1]) begin
      o_winner = w_cand1;
    end else if (i_req_vec[w_cand2]) begin
      o_winner = w_cand2;
    end
  end

endmodule

// File: rtl/regs_arbiter.sv
// Shares the single register-bank port between Tx, Rx, HReset and tcpm, one
// transfer at a time, with a watchdog that aborts unacknowledged transfers.
module regs_arbiter
  import regs_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_CLI-1:0]        i_req_vec,
  input  logic [NUM_CLI-1:0]        i_rwn_vec,
  input  logic [NUM_CLI*ADDR_W-1:0] i_addr_vec,
  input  logic [NUM_CLI*DATA_W-1:0] i_wr_data_vec,
  output logic [NUM_CLI-1:0]        o_ack_vec,
  output logic                      o_err,
  output logic [DATA_W-1:0]         o_rd_data_out,
  output logic [1:0]                o_grant_idx,
  output logic                      o_busy,
  output logic                      o_request,
  output logic                      o_rwn,
  output logic [ADDR_W-1:0]         o_addr,
  output logic [DATA_W-1:0]         o_wr_data,
  input  logic [DATA_W-1:0]         i_rd_data,
  input  logic                      i_ack
);

  localparam int              WD_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  state_e              r_state, w_state_next;
  logic [1:0]          r_rr_ptr, w_rr_ptr_next;
  logic [WD_W-1:0]     r_wd, w_wd_next;
  logic                r_request, w_request_next;
  logic                r_rwn, w_rwn_next;
  logic [ADDR_W-1:0]   r_addr, w_addr_next;
  logic [DATA_W-1:0]   r_wr_data, w_wr_data_next;
  logic [NUM_CLI-1:0]  r_ack_vec, w_ack_vec_next;
  logic                r_err, w_err_next;
  logic [DATA_W-1:0]   r_rd_data_out, w_rd_data_out_next;
  logic [1:0]          r_grant_idx, w_grant_idx_next;
  logic                r_busy, w_busy_next;

  logic [1:0]          w_pick_idx;
  logic                w_pick_valid;
  logic [ADDR_W-1:0]   w_addr_arr  [NUM_CLI];
  logic [DATA_W-1:0]   w_wdata_arr [NUM_CLI];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CLI; gi++) begin : g_unpack
      assign w_addr_arr[gi]  = i_addr_vec[gi*ADDR_W +: ADDR_W];
      assign w_wdata_arr[gi] = i_wr_data_vec[gi*DATA_W +: DATA_W];
    end
  endgenerate

  regs_arbiter_rr_picker u_picker (
    .i_req_vec (i_req_vec),
    .i_rr_ptr  (r_rr_ptr),
    .o_winner  (w_pick_idx),
    .o_valid   (w_pick_valid)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_rr_ptr      <= CLI_TX;
      r_wd          <= '0;
      r_request     <= 1'b0;
      r_rwn         <= 1'b0;
      r_addr        <= '0;
      r_wr_data     <= '0;
      r_ack_vec     <= '0;
      r_err         <= 1'b0;
      r_rd_data_out <= '0;
      r_grant_idx   <= '0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_rr_ptr      <= w_rr_ptr_next;
      r_wd          <= w_wd_next;
      r_request     <= w_request_next;
      r_rwn         <= w_rwn_next;
      r_addr        <= w_addr_next;
      r_wr_data     <= w_wr_data_next;
      r_ack_vec     <= w_ack_vec_next;
      r_err         <= w_err_next;
      r_rd_data_out <= w_rd_data_out_next;
      r_grant_idx   <= w_grant_idx_next;
      r_busy        <= w_busy_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:     if (w_pick_valid) w_state_next = ST_WAIT_ACK;
      ST_WAIT_ACK: if (i_ack || (r_wd == WD_LAST)) w_state_next = ST_RESP;
      ST_RESP:     w_state_next = ST_IDLE;
      default:     w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_rr_ptr_next      = r_rr_ptr;
    w_wd_next          = r_wd;
    w_request_next     = r_request;
    w_rwn_next         = r_rwn;
    w_addr_next        = r_addr;
    w_wr_data_next     = r_wr_data;
    w_ack_vec_next     = '0;
    w_err_next         = 1'b0;
    w_rd_data_out_next = r_rd_data_out;
    w_grant_idx_next   = r_grant_idx;
    w_busy_next        = r_busy;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) begin
          w_grant_idx_next = w_pick_idx;
          w_rwn_next       = i_rwn_vec[w_pick_idx];
          w_addr_next      = w_addr_arr[w_pick_idx];
          w_wr_data_next   = w_wdata_arr[w_pick_idx];
          w_request_next   = 1'b1;
          w_wd_next        = '0;
          w_busy_next      = 1'b1;
        end
      end
      ST_WAIT_ACK: begin
        // An ACK arriving on the timeout edge still counts as a normal completion.
        if (i_ack || (r_wd == WD_LAST)) begin
          w_request_next = 1'b0;
          w_ack_vec_next = NUM_CLI'(1) << r_grant_idx;
          if (r_grant_idx != CLI_HRESET) w_rr_ptr_next = rr_next(r_grant_idx);
          if (i_ack) begin
            if (r_rwn) w_rd_data_out_next = i_rd_data;
          end else begin
            w_err_next         = 1'b1;
            w_rd_data_out_next = '1;
          end
        end else begin
          w_wd_next = r_wd + WD_W'(1);
        end
      end
      ST_RESP: w_busy_next = 1'b0;
      default: ;
    endcase
  end

  assign o_ack_vec     = r_ack_vec;
  assign o_err         = r_err;
  assign o_rd_data_out = r_rd_data_out;
  assign o_grant_idx   = r_grant_idx;
  assign o_busy        = r_busy;
  assign o_request     = r_request;
  assign o_rwn         = r_rwn;
  assign o_addr        = r_addr;
  assign o_wr_data     = r_wr_data;

endmodule

// File: tb/tb_regs_arbiter.sv
// Self-checking bench for regs_arbiter: transaction-level reference model plus
// directed scenarios with literal expectations and a randomized soak.
module tb_regs_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    req_vec = '0;
  logic [3:0]    rwn_vec = '0;
  logic [4*AW-1:0] addr_vec = '0;
  logic [4*DW-1:0] wdata_vec = '0;
  logic          ack = 1'b0;
  logic [DW-1:0] rd_data = '0;

  logic [3:0]    o_ack_vec;
  logic          o_err;
  logic [DW-1:0] o_rd_data_out;
  logic [1:0]    o_grant_idx;
  logic          o_busy;
  logic          o_request;
  logic          o_rwn;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_wr_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  regs_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_req_vec     (req_vec),
    .i_rwn_vec     (rwn_vec),
    .i_addr_vec    (addr_vec),
    .i_wr_data_vec (wdata_vec),
    .o_ack_vec     (o_ack_vec),
    .o_err         (o_err),
    .o_rd_data_out (o_rd_data_out),
    .o_grant_idx   (o_grant_idx),
    .o_busy        (o_busy),
    .o_request     (o_request),
    .o_rwn         (o_rwn),
    .o_addr        (o_addr),
    .o_wr_data     (o_wr_data),
    .i_rd_data     (rd_data),
    .i_ack         (ack)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- register bank model ----------------
  int   bank_lat      = 0;     // -1: random latency per transfer
  bit   bank_spurious = 0;
  bit   bank_fixed    = 0;
  logic [DW-1:0] bank_data = '0;
  int   bank_cnt      = -1;
  int   bank_cur_lat  = 0;

  function automatic int rand_lat();
    int r;
    r = int'($urandom_range(0, 19));
    if (r < 12) return r % 4;
    if (r < 15) return TO - 1;
    if (r < 17) return TO + 4;
    return 4 + (r % 5);
  endfunction

  initial forever begin
    @(negedge clk);
    if (rst || !o_request) begin
      bank_cnt = -1;
      ack      = bank_spurious ? ($urandom_range(0, 7) == 0) : 1'b0;
      rd_data  = DW'($urandom);
    end else begin
      if (bank_cnt < 0) begin
        bank_cnt     = 0;
        bank_cur_lat = (bank_lat >= 0) ? bank_lat : rand_lat();
      end
      ack     = (bank_cnt == bank_cur_lat);
      rd_data = bank_fixed ? bank_data : DW'($urandom);
      bank_cnt++;
    end
  end

  // ---------------- reference model ----------------
  int   ring [3] = '{0, 1, 3};
  int   m_rr_last;        // ring position of the last non-HReset winner
  bit   m_outstanding;
  bit   m_gap;
  int   m_waited;
  logic          exp_request, exp_rwn, exp_err, exp_busy;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata, exp_rd;
  logic [3:0]    exp_ack_vec;
  logic [1:0]    exp_grant;

  function automatic int model_pick(input logic [3:0] r);
    int pos;
    if (r[2]) return 2;
    for (int k = 1; k <= 3; k++) begin
      pos = (m_rr_last + k) % 3;
      if (r[ring[pos]]) return ring[pos];
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_rr_last = 2; m_outstanding = 0; m_gap = 0; m_waited = 0;
    exp_request = 0; exp_rwn = 0; exp_err = 0; exp_busy = 0;
    exp_addr = '0; exp_wdata = '0; exp_rd = '0; exp_ack_vec = '0; exp_grant = '0;
  endtask

  task automatic model_finish(input bit timed_out);
    exp_request = 0;
    exp_ack_vec[exp_grant] = 1'b1;
    exp_err = timed_out;
    m_outstanding = 0;
    m_gap = 1;
    for (int k = 0; k < 3; k++) if (ring[k] == int'(exp_grant)) m_rr_last = k;
  endtask

  task automatic model_step();
    int w;
    exp_ack_vec = '0;
    exp_err = 0;
    if (m_gap) begin
      m_gap = 0;
      exp_busy = 0;
    end else if (m_outstanding) begin
      if (ack) begin
        model_finish(0);
        if (exp_rwn) exp_rd = rd_data;
      end else if (m_waited == TO - 1) begin
        model_finish(1);
        exp_rd = '1;
      end else begin
        m_waited++;
      end
    end else begin
      w = model_pick(req_vec);
      if (w >= 0) begin
        exp_grant     = 2'(w);
        exp_rwn       = rwn_vec[w];
        exp_addr      = addr_vec[w*AW +: AW];
        exp_wdata     = wdata_vec[w*DW +: DW];
        exp_request   = 1;
        exp_busy      = 1;
        m_outstanding = 1;
        m_waited      = 0;
      end
    end
  endtask

  always @(posedge clk) begin
    if (rst) model_reset();
    else     model_step();
    #1;
    cyc++;
    if (!rst) begin
      chk("request", 32'(o_request), 32'(exp_request));
      chk("ack_vec", 32'(o_ack_vec), 32'(exp_ack_vec));
      chk("err", 32'(o_err), 32'(exp_err));
      chk("rd_data_out", 32'(o_rd_data_out), 32'(exp_rd));
      chk("grant_idx", 32'(o_grant_idx), 32'(exp_grant));
      chk("busy", 32'(o_busy), 32'(exp_busy));
      if (exp_request) begin
        chk("rwn", 32'(o_rwn), 32'(exp_rwn));
        chk("addr", 32'(o_addr), 32'(exp_addr));
        chk("wr_data", 32'(o_wr_data), 32'(exp_wdata));
      end
      if (o_ack_vec != 0)
        $display("txn t=%0d cli=%0d rwn=%0b addr=%02h wdata=%02h rd=%02h err=%0b",
                 cyc, o_grant_idx, o_rwn, o_addr, o_wr_data, o_rd_data_out, o_err);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_ops(input int i, input logic rwn, input logic [AW-1:0] a, input logic [DW-1:0] d);
    rwn_vec[i] = rwn;
    addr_vec[i*AW +: AW] = a;
    wdata_vec[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    req_vec = '0;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic wait_ack(input string tag, output int req_cyc, output int waited,
                          output logic [3:0] av, output logic e, output logic [DW-1:0] rd);
    req_cyc = 0; waited = 0; av = '0; e = 0; rd = '0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      waited++;
      if (o_request) req_cyc++;
      if (o_ack_vec != 0) begin
        av = o_ack_vec; e = o_err; rd = o_rd_data_out;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL %s: no ACK_VEC pulse within 100 cycles (got none, required one)", tag);
  endtask

  task automatic wait_request(input string tag);
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (o_request) return;
    end
    checks++; errors++;
    $display("FAIL %s: REQUEST never rose (got 0, required 1)", tag);
  endtask

  logic [3:0] fair_exp [6] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
  logic [3:0] prio_exp [4] = '{4'b0001, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    int n, wt, pulses;
    logic [3:0] av;
    logic e;
    logic [DW-1:0] rd;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_request", 32'(o_request), 0);
    chk("rst_ack_vec", 32'(o_ack_vec), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_grant", 32'(o_grant_idx), 0);
    chk("rst_rd_data_out", 32'(o_rd_data_out), 0);
    rst = 0;

    // single read from Rx, bank acks in the second REQUEST cycle
    bank_lat = 1; bank_fixed = 1; bank_data = 8'hA5;
    @(negedge clk);
    set_ops(1, 1'b1, 8'h10, 8'h00);
    req_vec[1] = 1;
    wait_ack("rd", n, wt, av, e, rd);
    chk("rd_req_cycles", 32'(n), 2);
    chk("rd_ack_vec", 32'(av), 32'(4'b0010));
    chk("rd_err", 32'(e), 0);
    chk("rd_data", 32'(rd), 32'(8'hA5));
    req_vec[1] = 0;
    @(negedge clk);
    chk("rd_ack_pulse_width", 32'(o_ack_vec), 0);

    // fairness with zero-wait bank
    do_reset();
    bank_lat = 0; bank_fixed = 0;
    set_ops(0, 1'b0, 8'h01, 8'h11);
    set_ops(1, 1'b1, 8'h02, 8'h22);
    set_ops(3, 1'b0, 8'h03, 8'h33);
    req_vec = 4'b1011;
    for (int k = 0; k < 6; k++) begin
      wait_ack("fair", n, wt, av, e, rd);
      chk("fair_order", 32'(av), 32'(fair_exp[k]));
      if (k > 0) chk("fair_spacing", 32'(wt), 3);
    end
    req_vec = '0;

    // HReset priority without preemption
    do_reset();
    bank_lat = 3;
    set_ops(0, 1'b1, 8'h40, 8'h00);
    set_ops(2, 1'b0, 8'h41, 8'h99);
    set_ops(3, 1'b1, 8'h42, 8'h00);
    req_vec[0] = 1;
    wait_request("prio");
    req_vec[2] = 1; req_vec[3] = 1;
    for (int k = 0; k < 4; k++) begin
      wait_ack("prio", n, wt, av, e, rd);
      chk("prio_order", 32'(av), 32'(prio_exp[k]));
      if (av[2]) req_vec[2] = 0;
      if (av[3]) req_vec[3] = 0;
      if (k == 3) req_vec[0] = 0;
    end

    // timeout on a tcpm write
    do_reset();
    bank_lat = 1000;
    set_ops(3, 1'b0, 8'h22, 8'h5A);
    req_vec[3] = 1;
    wait_ack("to", n, wt, av, e, rd);
    chk("to_req_cycles", 32'(n), TO);
    chk("to_ack_vec", 32'(av), 32'(4'b1000));
    chk("to_err", 32'(e), 1);
    chk("to_rd_data", 32'(rd), 32'(8'hFF));
    req_vec[3] = 0;

    // late ACK on the timeout edge
    do_reset();
    bank_lat = TO - 1; bank_fixed = 1; bank_data = 8'h3C;
    set_ops(0, 1'b1, 8'h77, 8'h00);
    req_vec[0] = 1;
    wait_ack("late", n, wt, av, e, rd);
    chk("late_req_cycles", 32'(n), TO);
    chk("late_ack_vec", 32'(av), 32'(4'b0001));
    chk("late_err", 32'(e), 0);
    chk("late_rd_data", 32'(rd), 32'(8'h3C));
    req_vec[0] = 0;
    bank_fixed = 0;

    // reset in the middle of a transfer
    do_reset();
    bank_lat = 0;
    set_ops(0, 1'b0, 8'h50, 8'h01);
    set_ops(1, 1'b1, 8'h51, 8'h00);
    req_vec[0] = 1;
    wait_ack("mid_pre", n, wt, av, e, rd);
    chk("mid_pre_ack", 32'(av), 32'(4'b0001));
    req_vec[0] = 0;
    bank_lat = 1000;
    req_vec[1] = 1;
    wait_request("mid");
    repeat (3) @(negedge clk);
    #2 rst = 1;
    req_vec = '0;
    #1;
    chk("mid_async_request", 32'(o_request), 0);
    chk("mid_async_busy", 32'(o_busy), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (o_ack_vec != 0) pulses++;
    end
    chk("mid_no_ack_after_rst", 32'(pulses), 0);
    bank_lat = 0;
    req_vec = 4'b0011;
    wait_ack("mid_post", n, wt, av, e, rd);
    chk("mid_post_tx_first", 32'(av), 32'(4'b0001));
    req_vec = '0;

    // randomized soak against the model
    do_reset();
    bank_lat = -1; bank_spurious = 1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (req_vec[i] && o_ack_vec[i]) begin
          if ($urandom_range(0, 1) == 0) req_vec[i] = 0;
          else set_ops(i, 1'($urandom), AW'($urandom), DW'($urandom));
        end else if (req_vec[i]) begin
          if ($urandom_range(0, 59) == 0) req_vec[i] = 0;
        end else if ($urandom_range(0, (i == 2) ? 11 : 3) == 0) begin
          set_ops(i, 1'($urandom), AW'($urandom), DW'($urandom));
          req_vec[i] = 1;
        end
      end
    end
    req_vec = '0;
    bank_spurious = 0;
    repeat (30) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
